// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle SLL/SRL/SRA/ROTL unit shifting up to STEP positions per clock
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // STEP may equal WIDTH, which needs one bit more than a shift amount
    localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   work, shifted;
    logic [SHAMT_W-1:0] rem, k;
    logic [1:0]         mode_q;
    logic               accept;

    assign ready  = (state == IDLE) || (state == DONE);
    assign busy   = state == SHIFT;
    assign done   = state == DONE;
    assign accept = start && ready;

    // Step size, one step of the latched operation, and next state
    always_comb begin
        k = ({1'b0, rem} < STEP_W) ? rem : STEP_W[SHAMT_W-1:0];
        shifted = (mode_q == 2'b00) ? work << k :
                  (mode_q == 2'b01) ? work >> k :
                  (mode_q == 2'b10) ? $unsigned($signed(work) >>> k) :
                  (work << k) | (work >> (SHAMT_W'(0) - k));
        state_nxt = accept            ? ((shamt == '0) ? DONE : SHIFT) :
                    (state == SHIFT)  ? ((rem == k) ? DONE : SHIFT) :
                    (state == DONE)   ? IDLE : state;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand capture, per-cycle shifting and result write on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work   <= '0;
            rem    <= '0;
            mode_q <= '0;
            result <= '0;
        end else if (accept) begin
            work   <= a;
            rem    <= shamt;
            mode_q <= mode;
            if (shamt == '0) result <= a;
        end else if (state == SHIFT) begin
            work <= shifted;
            rem  <= rem - k;
            if (rem == k) result <= shifted;
        end
    end
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: randomized self-checking bench for seq_shifter across several STEP values
module tb_seq_shifter;
    logic        clk = 0;
    logic        rst = 1;
    logic        start [4];
    logic [1:0]  mode  [4];
    logic [31:0] a     [4];
    logic [4:0]  shamt [4];
    logic        ready [4];
    logic        busy  [4];
    logic        done  [4];
    logic [31:0] result[4];
    int          steps [4] = '{4, 1, 3, 32};
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        seq_shifter #(
            .WIDTH(32), .SHAMT_W(5),
            .STEP(g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 3 : 32)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start[g]), .mode(mode[g]), .a(a[g]),
            .shamt(shamt[g]), .ready(ready[g]), .busy(busy[g]), .done(done[g]),
            .result(result[g])
        );
    end

    // Reference: a single shift by s, built from the mode definitions
    function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] v, input int s);
        logic [63:0] d;
        logic [31:0] r;
        d = {v, v} << s;
        case (m)
            2'b00:   r = v << s;
            2'b01:   r = v >> s;
            2'b10:   r = (v >> s) | (v[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            default: r = d[63:32];
        endcase
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on unit u and wait for done; reports latency and busy cycles
    task automatic do_op(input int u, input logic [1:0] m, input logic [31:0] av, input logic [4:0] sh,
                         output int lat, output int bc, output logic [31:0] res);
        start[u] = 1; mode[u] = m; a[u] = av; shamt[u] = sh;
        tick;
        start[u] = 0; mode[u] = 2'($urandom); a[u] = $urandom; shamt[u] = 5'($urandom);
        lat = 1;
        bc = 0;
        while (!done[u] && lat < 200) begin
            if (busy[u]) bc++;
            tick;
            lat++;
        end
        res = result[u];
    endtask

    task automatic test_reset;
        rst = 1;
        #1;
        for (int u = 0; u < 4; u++) begin
            n_cmp++;
            if ({ready[u], busy[u], done[u], result[u]} !== {3'b100, 32'h0}) begin
                n_bad++;
                $display("FAIL reset u%0d: rdy/busy/done=%b%b%b result=%h want 100 00000000",
                         u, ready[u], busy[u], done[u], result[u]);
            end
        end
        tick;
        rst = 0;
        tick;
    endtask

    task automatic test_vectors;
        logic [1:0]  tm [10] = '{0, 2, 1, 3, 3, 0, 1, 2, 3, 1};
        logic [31:0] ta [10] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'h1234_5678,
                                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_FFFF};
        logic [4:0]  ts [10] = '{2, 31, 31, 1, 8, 0, 0, 0, 0, 4};
        logic [31:0] te [10] = '{32'h4, 32'hFFFF_FFFF, 32'h1, 32'h3, 32'h3456_7812,
                                 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0FFF};
        int          tb [10] = '{1, 8, 8, 1, 2, 0, 0, 0, 0, 1};
        int lat, bc;
        logic [31:0] res;
        for (int i = 0; i < 10; i++) begin
            do_op(0, tm[i], ta[i], ts[i], lat, bc, res);
            n_cmp++;
            if (res !== te[i] || bc != tb[i] || lat != tb[i] + 1) begin
                n_bad++;
                $display("FAIL vector%0d: result=%h busy=%0d lat=%0d want %h busy=%0d lat=%0d",
                         i, res, bc, lat, te[i], tb[i], tb[i] + 1);
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] av = $urandom;
        start[0] = 1; mode[0] = 2'b00; a[0] = av; shamt[0] = 16;
        tick;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_busy%0d: busy=%b done=%b want 1 0", i, busy[0], done[0]);
            end
            start[0] = 1; mode[0] = 2'($urandom); a[0] = $urandom; shamt[0] = 5'($urandom);
            tick;
        end
        n_cmp++;
        if (done[0] !== 1'b1 || result[0] !== av << 16) begin
            n_bad++;
            $display("FAIL b2b_first: done=%b result=%h want 1 %h", done[0], result[0], av << 16);
        end
        start[0] = 1; mode[0] = 2'b01; a[0] = 32'hF000_0000; shamt[0] = 4;
        tick;
        start[0] = 0;
        n_cmp++;
        if (busy[0] !== 1'b1 || done[0] !== 1'b0 || result[0] !== av << 16) begin
            n_bad++;
            $display("FAIL b2b_gap: busy=%b done=%b result=%h want 1 0 %h", busy[0], done[0], result[0], av << 16);
        end
        tick;
        n_cmp++;
        if (done[0] !== 1'b1 || result[0] !== 32'h0F00_0000) begin
            n_bad++;
            $display("FAIL b2b_second: done=%b result=%h want 1 0f000000", done[0], result[0]);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        start[0] = 1; mode[0] = 2'b00; a[0] = 32'hFFFF_FFFF; shamt[0] = 20;
        tick;
        start[0] = 0;
        tick;
        tick;
        rst = 1;
        #1;
        n_cmp++;
        if ({ready[0], busy[0], done[0], result[0]} !== {3'b100, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_mid: rdy/busy/done=%b%b%b result=%h want 100 00000000",
                     ready[0], busy[0], done[0], result[0]);
        end
        tick;
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            if (done[0] || busy[0]) seen++;
            tick;
        end
        n_cmp++;
        if (seen != 0 || ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_after: activity=%0d ready=%b want 0 1", seen, ready[0]);
        end
    endtask

    task automatic test_sweep;
        int lat, bc, n;
        logic [1:0]  m;
        logic [31:0] av, exp_r, res;
        logic [4:0]  sh;
        for (int u = 0; u < 4; u++) begin
            for (int i = 0; i < 40; i++) begin
                m = 2'($urandom_range(0, 3));
                av = $urandom;
                sh = 5'($urandom_range(0, 31));
                exp_r = ref_shift(m, av, int'(sh));
                n = (int'(sh) + steps[u] - 1) / steps[u];
                do_op(u, m, av, sh, lat, bc, res);
                n_cmp++;
                if (res !== exp_r || lat != n + 1 || bc != n) begin
                    n_bad++;
                    $display("FAIL sweep step=%0d mode=%0d a=%h sh=%0d: result=%h lat=%0d busy=%0d want %h lat=%0d busy=%0d",
                             steps[u], m, av, sh, res, lat, bc, exp_r, n + 1, n);
                end
                if ($urandom_range(0, 1) == 1) tick;
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 4; u++) begin
            start[u] = 0; mode[u] = 0; a[u] = 0; shamt[u] = 0;
        end
        test_reset;
        test_vectors;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
